// File: rtl/shift_arbiter_pkg.sv
// Shared constants and state encoding for the shift arbiter that sequences
// SLL/SRL/SRA through a single left-only barrel shifter.
package shift_arbiter_pkg;

    localparam int SA_W   = 32;
    localparam int SA_SHW = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [5:0] SIG_SHIFT = 6'b000000;
    localparam logic [5:0] SIG_OFF   = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_arbiter_bitrev.sv
// 32-bit bit reversal; lets a left-only shifter perform right shifts.
module bit_reverse32 (
    input  logic [31:0] in_i,
    output logic [31:0] out_o
);

    // Mirror bit i onto bit 31-i.
    always_comb begin
        out_o = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            out_o[i] = in_i[31-i];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter and sequencer sharing one external left-only shifter
// between two requesters; SRA takes a second pass to build the sign-fill mask.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int W   = SA_W,
    parameter int SHW = SA_SHW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [1:0]     req0_op,
    input  logic [1:0]     req1_op,
    input  logic [W-1:0]   req0_data,
    input  logic [W-1:0]   req1_data,
    input  logic [SHW-1:0] req0_shamt,
    input  logic [SHW-1:0] req1_shamt,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic [W-1:0]   sh_dataA,
    output logic [W-1:0]   sh_dataB,
    output logic [5:0]     sh_signal,
    input  logic [W-1:0]   sh_out
);

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   data_q, data_d;
    logic [SHW-1:0] shamt_q, shamt_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;

    logic           grant_s;
    logic [1:0]     sel_op_s;
    logic [W-1:0]   sel_data_s;
    logic [SHW-1:0] sel_shamt_s;
    logic [W-1:0]   data_rev_s;
    logic [W-1:0]   sh_out_rev_s;

    bit_reverse32 u_rev_operand (
        .in_i  (data_q),
        .out_o (data_rev_s)
    );

    bit_reverse32 u_rev_result (
        .in_i  (sh_out),
        .out_o (sh_out_rev_s)
    );

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_q;
            default: grant_s = 1'b0;
        endcase
    end

    // Operand mux for the granted requester.
    always_comb begin
        if (grant_s) begin
            sel_op_s    = req1_op;
            sel_data_s  = req1_data;
            sel_shamt_s = req1_shamt;
        end else begin
            sel_op_s    = req0_op;
            sel_data_s  = req0_data;
            sel_shamt_s = req0_shamt;
        end
    end

    // Next-state, datapath capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        op_d         = op_q;
        data_d       = data_q;
        shamt_d      = shamt_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = 2'b00;
        rsp_valid    = 2'b00;
        sh_signal    = SIG_OFF;
        sh_dataA     = {W{1'b0}};
        sh_dataB     = {W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (req_valid[grant_s]) begin
                    req_ready[grant_s] = 1'b1;
                    owner_d            = grant_s;
                    last_grant_d       = grant_s;
                    op_d               = sel_op_s;
                    data_d             = sel_data_s;
                    shamt_d            = sel_shamt_s;
                    if (sel_op_s == OP_RSV) begin
                        rsp_data_d = {W{1'b0}};
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        rsp_err_d  = 1'b0;
                        state_d    = ST_PASS1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS1: begin
                sh_signal = SIG_SHIFT;
                sh_dataB  = {{(W-SHW){1'b0}}, shamt_q};
                if (op_q == OP_SLL) begin
                    sh_dataA   = data_q;
                    rsp_data_d = sh_out;
                end else begin
                    sh_dataA   = data_rev_s;
                    rsp_data_d = sh_out_rev_s;
                end
                if (op_q == OP_SRA) begin
                    state_d = ST_PASS2;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_PASS2: begin
                // All-ones shifted left, reversed, is the logical-right mask; its complement is the sign fill.
                sh_signal = SIG_SHIFT;
                sh_dataA  = {W{1'b1}};
                sh_dataB  = {{(W-SHW){1'b0}}, shamt_q};
                if (data_q[W-1]) begin
                    rsp_data_d = rsp_data_q | ~sh_out_rev_s;
                end else begin
                    rsp_data_d = rsp_data_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and operand registers; reset makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= 2'b00;
            data_q       <= {W{1'b0}};
            shamt_q      <= {SHW{1'b0}};
            rsp_data_q   <= {W{1'b0}};
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            op_q         <= op_d;
            data_q       <= data_d;
            shamt_q      <= shamt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: vector table plus scoreboard,
// with an ideal left shifter modelled around the DUT.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv0 = 1'b0, rv1 = 1'b0;
    logic        rr0 = 1'b1, rr1 = 1'b1;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [1:0]  req0_op = 2'b00, req1_op = 2'b00;
    logic [31:0] req0_data = 32'h0, req1_data = 32'h0;
    logic [4:0]  req0_shamt = 5'd0, req1_shamt = 5'd0;
    logic [31:0] rsp_data, sh_dataA, sh_dataB, sh_out;
    logic        rsp_err;
    logic [5:0]  sh_signal;

    assign req_valid = {rv1, rv0};
    assign rsp_ready = {rr1, rr0};
    assign sh_out    = (sh_signal == 6'b000000) ? (sh_dataA << sh_dataB[4:0]) : 32'h0;

    shift_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .req0_shamt (req0_shamt),
        .req1_shamt (req1_shamt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .sh_dataA   (sh_dataA),
        .sh_dataB   (sh_dataB),
        .sh_signal  (sh_signal),
        .sh_out     (sh_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          t;
    } exp_t;

    typedef struct {
        int          r;
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] ed;
        logic        ee;
        int          el;
    } vec_t;

    exp_t sb[$];
    int   grants[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input int r, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] sh, input logic [31:0] ed, input logic ee, input int el);
        exp_t e;
        bit   done = 1'b0;
        @(posedge clk); #1;
        if (r == 0) begin
            rv0 = 1'b1; req0_op = op; req0_data = d; req0_shamt = sh;
        end else begin
            rv1 = 1'b1; req1_op = op; req1_data = d; req1_shamt = sh;
        end
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                @(posedge clk); #1;
                e.owner = r[0];
                e.data  = ed;
                e.err   = ee;
                e.lat   = el;
                e.t     = cyc - 1;
                sb.push_back(e);
                grants.push_back(r);
                done = 1'b1;
            end
        end
        if (r == 0) rv0 = 1'b0; else rv1 = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL handshake_timeout req%0d: got no req_ready want a grant", r);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && rsp_valid == 2'b00) ok = 1'b1;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, {30'b0, req_ready}, 32'h0);
        chk({tag, "_rsp_valid"}, {30'b0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_data"},  rsp_data, 32'h0);
        chk({tag, "_rsp_err"},   {31'b0, rsp_err}, 32'h0);
        chk({tag, "_sh_signal"}, {26'b0, sh_signal}, 32'h3F);
        chk({tag, "_sh_dataA"},  sh_dataA, 32'h0);
        chk({tag, "_sh_dataB"},  sh_dataB, 32'h0);
    endtask

    // Response monitor: stability while stalled, then pop and compare on handshake.
    initial begin : monitor
        exp_t        e;
        logic        in_resp = 1'b0;
        int          first_cyc = 0;
        logic [31:0] held_d = 32'h0;
        logic [1:0]  held_v = 2'b00;
        forever begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                if (!in_resp) begin
                    in_resp   = 1'b1;
                    first_cyc = cyc;
                    held_d    = rsp_data;
                    held_v    = rsp_valid;
                end else begin
                    chk("rsp_data_stable", rsp_data, held_d);
                    chk("rsp_valid_stable", {30'b0, rsp_valid}, {30'b0, held_v});
                end
                if ((rsp_valid & rsp_ready) != 2'b00) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rsp: got rsp_valid %b want none", rsp_valid);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_owner", {30'b0, rsp_valid}, e.owner ? 32'h2 : 32'h1);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                        chk("latency", first_cyc - e.t, e.lat);
                    end
                    in_resp = 1'b0;
                end
            end else begin
                in_resp = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t tbl[12];
        tbl[0]  = '{0, OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 2};
        tbl[1]  = '{1, OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 2};
        tbl[2]  = '{0, OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 3};
        tbl[3]  = '{0, OP_SRA, 32'h4000_0000, 5'd4,  32'h0400_0000, 1'b0, 3};
        tbl[4]  = '{1, OP_SRA, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 3};
        tbl[5]  = '{0, OP_SRL, 32'hF0F0_F0F0, 5'd0,  32'hF0F0_F0F0, 1'b0, 2};
        tbl[6]  = '{1, OP_SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 2};
        tbl[7]  = '{0, OP_RSV, 32'hDEAD_BEEF, 5'd5,  32'h0000_0000, 1'b1, 1};
        tbl[8]  = '{1, OP_SRA, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1'b0, 3};
        tbl[9]  = '{0, OP_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 2};
        tbl[10] = '{1, OP_SRA, 32'h8765_4321, 5'd8,  32'hFF87_6543, 1'b0, 3};
        tbl[11] = '{1, OP_SLL, 32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50, 1'b0, 2};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].r, tbl[i].op, tbl[i].d, tbl[i].sh, tbl[i].ed, tbl[i].ee, tbl[i].el);
            drain();
        end

        // Both requesters always valid: grants must alternate starting with 0.
        grants.delete();
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(0, OP_SLL, 32'h10 + i, 5'd1, (32'h10 + i) << 1, 1'b0, 2);
            end
            begin
                for (int j = 0; j < 4; j++)
                    send(1, OP_SLL, 32'h100 + j, 5'd1, (32'h100 + j) << 1, 1'b0, 2);
            end
        join
        drain();
        chk("rr_grant_count", grants.size(), 32'd8);
        for (int k = 0; k < grants.size(); k++)
            chk("rr_grant_order", grants[k], k % 2);

        // Requester 1 stalls its response while requester 0 waits.
        @(posedge clk); #1;
        rr1 = 1'b0;
        fork
            send(1, OP_SRL, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 2);
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clk);
                    if (rsp_valid[1]) seen = 1'b1;
                end
                chk("bp_rsp_seen", {31'b0, seen}, 32'h1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_req_ready", {30'b0, req_ready}, 32'h0);
                    chk("bp_rsp_valid", {30'b0, rsp_valid}, 32'h2);
                end
                @(posedge clk); #1;
                rr1 = 1'b1;
            end
            begin
                repeat (3) @(posedge clk);
                send(0, OP_SLL, 32'h0000_00F0, 5'd8, 32'h0000_F000, 1'b0, 2);
            end
        join
        drain();

        // Reset while an SRA is in its second pass.
        send(0, OP_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 3);
        @(posedge clk); #1;
        chk("pass2_sh_signal", {26'b0, sh_signal}, 32'h0);
        chk("pass2_sh_dataA", sh_dataA, 32'hFFFF_FFFF);
        rst = 1'b1;
        #1;
        chk_reset_values("midrst");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, OP_SLL, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Sequencer and arbiter that shares the single 32-bit left-only barrel shifter between two requesters, e.g. the EX-stage ALU and the multiply/divide unit.
- Provides SLL, SRL and SRA on top of the left-only datapath.
  - SRL is built by bit-reversing the operand, shifting left, then bit-reversing the result.
  - SRA uses a second pass through the shifter to build the sign-fill mask.
- Requests and responses use valid/ready handshakes. Each response returns to the requester that issued the request.

Parameters:
- W, 32, data width; fixed at 32 to match the shifter.
- SHW, 5, shift-amount width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester request accept
- req0_op / req1_op  in  2 each  opcode: 00 SLL, 01 SRL, 10 SRA, 11 reserved
- req0_data / req1_data  in  32 each  operand
- req0_shamt / req1_shamt  in  5 each  shift amount
- rsp_valid  out  2  per-requester result valid
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  32  result, shared by both requesters; qualified by rsp_valid
- rsp_err  out  1  reserved opcode flag; qualified by rsp_valid
- sh_dataA  out  32  to shifter operand
- sh_dataB  out  32  to shifter amount, zero-extended shamt
- sh_signal  out  6  to shifter; 6'b000000 = shift, 6'b111111 = output forced to zero
- sh_out  in  32  from shifter result (combinational)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; last_grant=1, so requester 0 wins first.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - sh_signal=6'b111111, sh_dataA=0, sh_dataB=0.
- FSM states: IDLE, PASS1, PASS2, RESP.
- IDLE, arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester other than last_grant (round robin).
  - req_ready[g]=1 combinationally only in IDLE, and only for the granted g.
  - On req_valid[g]&&req_ready[g]: latch op, data, shamt and owner=g; set last_grant=g; go to PASS1.
  - Reserved opcode: go straight to RESP with rsp_data=0, rsp_err=1.
- PASS1:
  - sh_signal=000000 and sh_dataB={27'b0,shamt}.
  - sh_dataA = data for SLL; rev(data) for SRL and SRA.
  - End of cycle: capture tmp = sh_out for SLL, rev(sh_out) for SRL/SRA.
  - SLL/SRL go to RESP. SRA goes to PASS2.
- PASS2 (SRA only):
  - sh_dataA = 32'hFFFFFFFF; sh_dataB unchanged.
  - mask = rev(sh_out), which equals 0xFFFFFFFF >> shamt.
  - Result = tmp | (data[31] ? ~mask : 0). Go to RESP.
- Outside PASS1/PASS2: sh_signal=6'b111111 and sh_dataA/sh_dataB=0, keeping the shifter quiet.
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[owner]: go to IDLE and deassert rsp_valid next cycle.
  - Backpressure is unlimited; the other requester keeps waiting.
- Latency from request handshake at cycle T:
  - SLL/SRL: rsp_valid at T+2.
  - SRA: rsp_valid at T+3.
  - Reserved opcode: rsp_valid at T+1.
- Throughput: no request is accepted in the cycle its predecessor's response handshakes. Minimum spacing between accepts is 3 cycles for SLL/SRL.
- shamt=0 returns data unchanged for all ops. For SRA, ~mask=0 in that case.
- rst asserted mid-operation aborts immediately. Nothing is responded and latched operands are discarded.
- A requester dropping req_valid before handshake is legal; arbitration re-evaluates every IDLE cycle.
- rsp_ready on a non-owner bit is ignored.

Decomposition:
- Package shift_arbiter_pkg holds:
  - Opcode constants OP_SLL, OP_SRL, OP_SRA.
  - State encoding.
  - SIG_SHIFT=6'b000000 and SIG_OFF=6'b111111.
- One combinational sub-module, bit_reverse32, instantiated for the operand path and the result path.
- The shifter itself stays outside; it connects through the sh_* ports.

Test Plan:
- Req0 SLL, data 0x00000001, shamt 31 -> rsp_valid[0] at T+2, rsp_data 0x80000000, rsp_err 0.
- Req1 SRL, data 0x80000000, shamt 4 -> rsp_valid[1] at T+2, rsp_data 0x08000000.
- Req0 SRA, data 0x80000000, shamt 4 -> rsp_data 0xF8000000 at T+3. Same with data 0x40000000 -> 0x04000000.
- Both requesters valid continuously with SLL, shamt 1 -> grants alternate 0,1,0,1. Each response goes only to its owner.
- Req1 holds rsp_ready=0 for 5 cycles -> rsp_valid[1] and rsp_data stay stable. req_ready stays 0 even with req0 valid.
- rst pulse during PASS2 of an SRA -> all outputs return to reset values immediately. The next req0 SLL, data 0x3, shamt 2 -> 0x0000000C.
